// File: rtl/vcxo_pkg.sv
// Shared definitions for the VCXO discipline controller: state encoding,
// tuning-mode constants, default PWM geometry and the duty clamp helper.
package vcxo_pkg;

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned DUTY_W = 16;

   localparam int unsigned PWM_MAX_DEF  = 60000;
   localparam int unsigned PWM_INIT_DEF = 30000;

   localparam logic MODE_COARSE = 1'b0;
   localparam logic MODE_FINE   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATE   = 3'd1,
      ST_CALC   = 3'd2,
      ST_ADJUST = 3'd3,
      ST_APPLY  = 3'd4
   } state_e;

   // Clamp a signed 33-bit candidate duty into [1, pwm_max-1].
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [32:0] val,
                                                    input int unsigned        pwm_max);
      logic signed [32:0] hi;
      hi = $signed(33'(pwm_max - 1));
      if (val < 33'sd1) begin
         return DUTY_W'(1);
      end else if (val > hi) begin
         return DUTY_W'(hi);
      end else begin
         return DUTY_W'(val);
      end
   endfunction

endpackage

// File: rtl/vcxo_pwm_gen.sv
// PWM generator driving the loop-filter pump.
// Ports: clk_in  - system clock
//        reset   - asynchronous active-high reset
//        duty    - requested duty word, latched only at period wrap
//        pump    - registered PWM output, high while counter < latched duty
module vcxo_pwm_gen
   import vcxo_pkg::*;
#(
   parameter int unsigned PWM_MAX  = PWM_MAX_DEF,
   parameter int unsigned PWM_INIT = PWM_INIT_DEF
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [DUTY_W-1:0] duty,
   output logic              pump
);

   localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_MAX - 1);
   localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(PWM_INIT);

   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic [DUTY_W-1:0] lat_q, lat_d;
   logic              pump_q, pump_d;

   // Period counter; duty is only re-sampled at wrap so a period is never cut short.
   always_comb begin
      cnt_d  = cnt_q + DUTY_W'(1);
      lat_d  = lat_q;
      pump_d = (cnt_q < lat_q);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         lat_d = duty;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         lat_q  <= DUTY_RST;
         pump_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         pump_q <= pump_d;
      end
   end

   assign pump = pump_q;

endmodule

// File: rtl/vcxo_lock_sequencer.sv
// VCXO discipline controller: counts VCXO ticks over a gate window, forms a
// signed frequency error against the trimmed nominal count, and steers the
// PWM duty word through coarse (proportional) and fine (+/-1) tuning.
// Ports: clk_in, reset (async, active-high)
//        vcxo_tick       - one strobe per synchronised VCXO edge
//        enable          - run the measurement loop
//        VCXO_correction - signed trim added to the error
//        freq_error      - last committed error
//        pwm_duty        - current duty word
//        pump            - PWM output to the loop filter
//        PWM_mode        - 0 coarse, 1 fine
//        locked          - high while in fine mode
//        meas_valid      - one-cycle pulse after each committed measurement
module vcxo_lock_sequencer
   import vcxo_pkg::*;
#(
   parameter int unsigned GATE_CYCLES   = 1000000,
   parameter int unsigned NOMINAL_COUNT = 6144000,
   parameter int unsigned PWM_MAX       = PWM_MAX_DEF,
   parameter int unsigned PWM_INIT      = PWM_INIT_DEF,
   parameter int unsigned COARSE_BAND   = 10,
   parameter int unsigned LOCK_COUNT    = 10
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     vcxo_tick,
   input  logic                     enable,
   input  logic signed [15:0]       VCXO_correction,
   output logic signed [CNT_W-1:0]  freq_error,
   output logic [DUTY_W-1:0]        pwm_duty,
   output logic                     pump,
   output logic                     PWM_mode,
   output logic                     locked,
   output logic                     meas_valid
);

   localparam logic [CNT_W-1:0]  GATE_LAST = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  NOMINAL   = CNT_W'(NOMINAL_COUNT);
   localparam logic [CNT_W-1:0]  LOCK_SAT  = CNT_W'(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0]  LOCK_THR  = CNT_W'(LOCK_COUNT);
   localparam logic [32:0]       BAND      = 33'(COARSE_BAND);
   localparam logic [DUTY_W-1:0] DUTY_RST  = DUTY_W'(PWM_INIT);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]         tick_cnt_q, tick_cnt_d;
   logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
   logic signed [CNT_W-1:0]  err_q, err_d;
   logic signed [32:0]       new_q, new_d;
   logic                     pend_mode_q, pend_mode_d;
   logic signed [CNT_W-1:0]  ferr_q, ferr_d;
   logic [DUTY_W-1:0]        duty_q, duty_d;
   logic                     mode_q, mode_d;
   logic                     locked_q, locked_d;
   logic                     valid_q, valid_d;

   logic signed [32:0]       err33, duty33, step33, coarse33;
   logic [32:0]              err_mag;
   logic                     big_err;

   // Candidate duty values; 33-bit so duty - err cannot wrap before clamping.
   always_comb begin
      err33    = $signed({err_q[CNT_W-1], err_q});
      duty33   = $signed({17'b0, duty_q});
      err_mag  = err_q[CNT_W-1] ? -err33 : err33;
      big_err  = (err_mag > BAND);
      if (err_q[CNT_W-1]) begin
         step33 = duty33 + 33'sd1;
      end else if (err_q != '0) begin
         step33 = duty33 - 33'sd1;
      end else begin
         step33 = duty33;
      end
      coarse33 = big_err ? (duty33 - err33) : step33;
   end

   // Measurement sequencer next-state and datapath.
   always_comb begin
      state_d     = state_q;
      gate_cnt_d  = gate_cnt_q;
      tick_cnt_d  = tick_cnt_q;
      lock_cnt_d  = lock_cnt_q;
      err_d       = err_q;
      new_d       = new_q;
      pend_mode_d = pend_mode_q;
      ferr_d      = ferr_q;
      duty_d      = duty_q;
      mode_d      = mode_q;
      locked_d    = locked_q;
      valid_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d    = ST_GATE;
               gate_cnt_d = '0;
               tick_cnt_d = '0;
            end
         end
         ST_GATE: begin
            if (!enable) begin
               // Partial count is discarded on the next IDLE exit.
               state_d = ST_IDLE;
            end else begin
               if (vcxo_tick && (tick_cnt_q != '1)) begin
                  tick_cnt_d = tick_cnt_q + CNT_W'(1);
               end
               if (gate_cnt_q == GATE_LAST) begin
                  state_d = ST_CALC;
               end else begin
                  gate_cnt_d = gate_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_CALC: begin
            err_d = $signed(tick_cnt_q) - $signed(NOMINAL)
                  + $signed({{16{VCXO_correction[15]}}, VCXO_correction});
            if (err_d == '0) begin
               if (lock_cnt_q < LOCK_SAT) begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end else begin
               lock_cnt_d = '0;
            end
            state_d = ST_ADJUST;
         end
         ST_ADJUST: begin
            if (mode_q == MODE_FINE) begin
               // A large error drops back to coarse and uses the coarse rule now.
               if (big_err) begin
                  pend_mode_d = MODE_COARSE;
                  new_d       = coarse33;
               end else begin
                  pend_mode_d = MODE_FINE;
                  new_d       = step33;
               end
            end else begin
               new_d       = coarse33;
               pend_mode_d = MODE_COARSE;
               if (lock_cnt_q > LOCK_THR) begin
                  pend_mode_d = MODE_FINE;
                  lock_cnt_d  = '0;
               end
            end
            state_d = ST_APPLY;
         end
         ST_APPLY: begin
            duty_d     = clamp_duty(new_q, PWM_MAX);
            ferr_d     = err_q;
            mode_d     = pend_mode_q;
            locked_d   = pend_mode_q;
            valid_d    = 1'b1;
            gate_cnt_d = '0;
            tick_cnt_d = '0;
            state_d    = enable ? ST_GATE : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         gate_cnt_q  <= '0;
         tick_cnt_q  <= '0;
         lock_cnt_q  <= '0;
         err_q       <= '0;
         new_q       <= '0;
         pend_mode_q <= MODE_COARSE;
         ferr_q      <= '0;
         duty_q      <= DUTY_RST;
         mode_q      <= MODE_COARSE;
         locked_q    <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         gate_cnt_q  <= gate_cnt_d;
         tick_cnt_q  <= tick_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         err_q       <= err_d;
         new_q       <= new_d;
         pend_mode_q <= pend_mode_d;
         ferr_q      <= ferr_d;
         duty_q      <= duty_d;
         mode_q      <= mode_d;
         locked_q    <= locked_d;
         valid_q     <= valid_d;
      end
   end

   vcxo_pwm_gen #(
      .PWM_MAX  (PWM_MAX),
      .PWM_INIT (PWM_INIT)
   ) u_pwm (
      .clk_in (clk_in),
      .reset  (reset),
      .duty   (duty_q),
      .pump   (pump)
   );

   assign freq_error = ferr_q;
   assign pwm_duty   = duty_q;
   assign PWM_mode   = mode_q;
   assign locked     = locked_q;
   assign meas_valid = valid_q;

endmodule

// File: tb/tb_vcxo_lock_sequencer.sv
// Directed bench for vcxo_lock_sequencer with reduced gate/PWM geometry.
module tb_vcxo_lock_sequencer;

   localparam int GATE = 100;

   logic               clk_in;
   logic               reset;
   logic               vcxo_tick;
   logic               enable;
   logic signed [15:0] VCXO_correction;
   logic signed [31:0] freq_error;
   logic [15:0]        pwm_duty;
   logic               pump;
   logic               PWM_mode;
   logic               locked;
   logic               meas_valid;

   vcxo_lock_sequencer #(
      .GATE_CYCLES   (100),
      .NOMINAL_COUNT (50),
      .PWM_MAX       (200),
      .PWM_INIT      (100),
      .COARSE_BAND   (10),
      .LOCK_COUNT    (10)
   ) dut (
      .clk_in          (clk_in),
      .reset           (reset),
      .vcxo_tick       (vcxo_tick),
      .enable          (enable),
      .VCXO_correction (VCXO_correction),
      .freq_error      (freq_error),
      .pwm_duty        (pwm_duty),
      .pump            (pump),
      .PWM_mode        (PWM_mode),
      .locked          (locked),
      .meas_valid      (meas_valid)
   );

   typedef struct {
      int   ticks;
      int   corr;
      int   exp_err;
      int   exp_duty;
      logic exp_mode;
   } vec_t;

   vec_t vecs[20];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   runs[$];
   int   rises[$];
   int   rise_cyc = 0;
   logic pump_prev = 1'b0;

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cyc = cyc + 1;

   // Record pump high-run lengths and rise times.
   always @(negedge clk_in) begin
      if (pump && !pump_prev) begin
         rise_cyc = cyc;
         rises.push_back(cyc);
      end
      if (!pump && pump_prev) runs.push_back(cyc - rise_cyc);
      pump_prev = pump;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_in);
      #1;
   endtask

   // Starts in gate cycle 0; returns #1 after the commit edge.
   task automatic run_meas(input int ticks);
      for (int i = 0; i < GATE; i++) begin
         vcxo_tick = (i < ticks);
         cycle();
         if (i == 0) check("meas_valid_width", 32'(meas_valid), 32'd0);
      end
      vcxo_tick = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic wait_runs(input int n, input int limit);
      int t;
      t = 0;
      while (runs.size() < n && t < limit) begin
         cycle();
         t++;
      end
      check("pwm_run_wait", runs.size(), n);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_freq_error"}, freq_error, 32'sd0);
      check({tag, "_pwm_duty"},   32'(pwm_duty), 32'd100);
      check({tag, "_pump"},       32'(pump), 32'd0);
      check({tag, "_mode"},       32'(PWM_mode), 32'd0);
      check({tag, "_locked"},     32'(locked), 32'd0);
      check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
   endtask

   initial begin
      int nv;
      int t;

      reset           = 1'b1;
      enable          = 1'b0;
      vcxo_tick       = 1'b0;
      VCXO_correction = '0;

      vecs[0] = '{60,    0,   10,  99, 1'b0};
      vecs[1] = '{49,    0,   -1, 100, 1'b0};
      vecs[2] = '{70,    0,   20,  80, 1'b0};
      vecs[3] = '{50, -150, -150, 199, 1'b0};
      vecs[4] = '{50,  300,  300,   1, 1'b0};
      vecs[5] = '{50,  -99,  -99, 100, 1'b0};
      for (int k = 6; k < 17; k++) vecs[k] = '{50, 0, 0, 100, (k == 16)};
      vecs[17] = '{51,   0,    1,  99, 1'b1};
      vecs[18] = '{60,   0,   10,  98, 1'b1};
      vecs[19] = '{70,   0,   20,  78, 1'b0};

      repeat (3) cycle();
      check_reset_outputs("reset");
      reset = 1'b0;
      cycle();
      enable = 1'b1;
      cycle();

      // Back-to-back measurements: step rules, clamping, lock entry, fine mode, fallback.
      for (int k = 0; k < 20; k++) begin
         VCXO_correction = 16'(vecs[k].corr);
         run_meas(vecs[k].ticks);
         check($sformatf("vec%0d_meas_valid", k), 32'(meas_valid), 32'd1);
         check($sformatf("vec%0d_freq_error", k), freq_error, 32'(vecs[k].exp_err));
         check($sformatf("vec%0d_pwm_duty", k), 32'(pwm_duty), 32'(vecs[k].exp_duty));
         check($sformatf("vec%0d_mode", k), 32'(PWM_mode), 32'(vecs[k].exp_mode));
         check($sformatf("vec%0d_locked", k), 32'(locked), 32'(vecs[k].exp_mode));
      end

      // Enable dropped at gate cycle 40: partial count discarded, outputs held.
      VCXO_correction = '0;
      for (int i = 0; i < 40; i++) begin
         vcxo_tick = 1'b1;
         cycle();
      end
      vcxo_tick = 1'b0;
      enable    = 1'b0;
      nv = 0;
      for (int i = 0; i < 150; i++) begin
         cycle();
         if (meas_valid) nv++;
      end
      check("drop_no_meas_valid", nv, 0);
      check("drop_duty_held", 32'(pwm_duty), 32'd78);
      check("drop_error_held", freq_error, 32'sd20);
      check("drop_mode_held", 32'(PWM_mode), 32'd0);
      enable = 1'b1;
      cycle();
      run_meas(50);
      check("rearm_meas_valid", 32'(meas_valid), 32'd1);
      check("rearm_freq_error", freq_error, 32'sd0);
      check("rearm_pwm_duty", 32'(pwm_duty), 32'd78);

      // Asynchronous reset at gate cycle 40.
      for (int i = 0; i < 40; i++) begin
         vcxo_tick = (i % 2 == 0);
         cycle();
      end
      vcxo_tick = 1'b0;
      enable    = 1'b0;
      reset     = 1'b1;
      #1;
      check_reset_outputs("midgate_reset");
      cycle();
      reset = 1'b0;
      cycle();

      // PWM high time at duty 50.
      enable = 1'b1;
      cycle();
      run_meas(100);
      check("pwm50_freq_error", freq_error, 32'sd50);
      check("pwm50_pwm_duty", 32'(pwm_duty), 32'd50);
      enable = 1'b0;
      repeat (450) cycle();
      runs.delete();
      rises.delete();
      t = 0;
      while ((runs.size() < 2 || rises.size() < 2) && t < 700) begin
         cycle();
         t++;
      end
      check("pwm50_wait", 32'(t < 700), 32'd1);
      if (runs.size() >= 2 && rises.size() >= 2) begin
         check("pwm50_run0", runs[0], 50);
         check("pwm50_run1", runs[1], 50);
         check("pwm50_period", rises[1] - rises[0], 200);
      end

      // Duty write in the middle of a high run takes effect from the next period.
      runs.delete();
      wait_runs(1, 400);
      repeat (65) cycle();
      VCXO_correction = -16'sd30;
      enable = 1'b1;
      cycle();
      run_meas(50);
      enable = 1'b0;
      check("midwrite_pump_high", 32'(pump), 32'd1);
      check("midwrite_pwm_duty", 32'(pwm_duty), 32'd80);
      runs.delete();
      wait_runs(3, 1000);
      if (runs.size() >= 3) begin
         check("midwrite_run_current", runs[0], 50);
         check("midwrite_run_next", runs[1], 80);
         check("midwrite_run_after", runs[2], 80);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
